// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one combinational IEEE-754 single-precision multiplier
// between NUM_REQ requesters, one operation in flight, operands held for MUL_CYCLES clocks.

module floating_point_mul (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] product
);
    logic               sign;
    logic [7:0]         ea, eb, ea_eff, eb_eff, exp_base;
    logic [23:0]        ma, mb;
    logic [47:0]        prod, norm;
    logic [95:0]        wide;
    logic [5:0]         lz;
    logic signed [10:0] exp_n;
    logic [6:0]         rsh;
    logic               guard, sticky, round_up;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [30:0]        packed_mag;

    always_comb begin
        sign   = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        ma     = {ea != 8'd0, a[22:0]};
        mb     = {eb != 8'd0, b[22:0]};
        ea_eff = (ea == 8'd0) ? 8'd1 : ea;
        eb_eff = (eb == 8'd0) ? 8'd1 : eb;
        a_nan  = (&ea) && (|a[22:0]);
        b_nan  = (&eb) && (|b[22:0]);
        a_inf  = (&ea) && !(|a[22:0]);
        b_inf  = (&eb) && !(|b[22:0]);
        a_zero = !(|a[30:0]);
        b_zero = !(|b[30:0]);
        prod   = {24'd0, ma} * {24'd0, mb};

        lz = 6'd0;
        for (int i = 0; i < 48; i++) begin
            if (prod[i]) lz = 6'(47 - i);
        end
        norm  = prod << lz;
        exp_n = $signed({3'b000, ea_eff}) + $signed({3'b000, eb_eff})
              - 11'sd126 - $signed({5'b00000, lz});

        // Results below the normal range are shifted right into subnormal form;
        // the hidden bit is added back into the exponent field so a rounding
        // carry can promote a subnormal to the smallest normal, or a normal to infinity.
        if (exp_n <= 11'sd0) begin
            rsh      = (exp_n < -11'sd48) ? 7'd50 : 7'(11'sd1 - exp_n);
            exp_base = 8'd0;
        end else begin
            rsh      = 7'd0;
            exp_base = 8'(exp_n - 11'sd1);
        end
        wide       = {norm, 48'd0} >> rsh;
        guard      = wide[71];
        sticky     = |wide[70:0];
        round_up   = guard & (sticky | wide[72]);
        packed_mag = {exp_base, 23'd0} + {7'd0, wide[95:72]} + 31'(round_up);

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            product = 32'h7FC00000;
        else if (a_inf || b_inf)
            product = {sign, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
            product = {sign, 31'd0};
        else if (exp_n >= 11'sd255)
            product = {sign, 8'hFF, 23'd0};
        else
            product = {sign, packed_mag};
    end
endmodule

module fp_mul_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int MUL_CYCLES = 1,
    parameter int ID_W       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [31:0]           rsp_product,
    output logic                  busy,
    output logic [ID_W-1:0]       grant_id
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t          state_reg, state_next;
    logic [ID_W-1:0] last_grant_reg, grant_id_reg, win_id;
    logic [3:0]      cnt_reg;
    logic [31:0]     op_a_reg, op_b_reg, product_reg, mul_product;
    logic [31:0]     slice_a [NUM_REQ];
    logic [31:0]     slice_b [NUM_REQ];
    logic            win_found, rsp_done;

    floating_point_mul u_mul (
        .a       (op_a_reg),
        .b       (op_b_reg),
        .product (mul_product)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign slice_a[gi]   = req_a[32*gi +: 32];
            assign slice_b[gi]   = req_b[32*gi +: 32];
            assign req_ready[gi] = (state_reg == IDLE) && win_found && (win_id == ID_W'(gi));
            assign rsp_valid[gi] = (state_reg == RESP) && (grant_id_reg == ID_W'(gi));
        end
    endgenerate

    // Search downward so the requester closest after last_grant is assigned last and wins.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_grant_reg) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    assign rsp_done    = (state_reg == RESP) && rsp_ready[grant_id_reg];
    assign busy        = (state_reg != IDLE);
    assign grant_id    = grant_id_reg;
    assign rsp_product = product_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (win_found) state_next = CALC;
            CALC:    if (cnt_reg == 4'd0) state_next = RESP;
            RESP:    if (rsp_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
            grant_id_reg   <= '0;
            cnt_reg        <= 4'd0;
            op_a_reg       <= 32'd0;
            op_b_reg       <= 32'd0;
            product_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (win_found) begin
                    op_a_reg     <= slice_a[win_id];
                    op_b_reg     <= slice_b[win_id];
                    grant_id_reg <= win_id;
                    cnt_reg      <= 4'(MUL_CYCLES - 1);
                end
                CALC: begin
                    if (cnt_reg != 4'd0) cnt_reg <= cnt_reg - 4'd1;
                    else                 product_reg <= mul_product;
                end
                RESP: if (rsp_done) last_grant_reg <= grant_id_reg;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter: one instance with MUL_CYCLES=1 and one with MUL_CYCLES=4.

module tb_fp_mul_arbiter;
    logic        clk, rst;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0] req_a, req_b;
    logic [31:0] rsp_product;
    logic        busy;
    logic [0:0]  grant_id;

    logic [1:0]  req_valid4, req_ready4, rsp_valid4, rsp_ready4;
    logic [63:0] req_a4, req_b4;
    logic [31:0] rsp_product4;
    logic        busy4;
    logic [0:0]  grant_id4;

    int checks = 0;
    int errors = 0;

    fp_mul_arbiter #(.NUM_REQ(2), .MUL_CYCLES(1), .ID_W(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_product(rsp_product), .busy(busy), .grant_id(grant_id)
    );

    fp_mul_arbiter #(.NUM_REQ(2), .MUL_CYCLES(4), .ID_W(1)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_a(req_a4), .req_b(req_b4), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
        .rsp_product(rsp_product4), .busy(busy4), .grant_id(grant_id4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant_id got=%b exp=0", grant_id); end
        checks++; if (rsp_product !== 32'h0) begin errors++; $display("FAIL reset_product got=%h exp=00000000", rsp_product); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4 got=%b exp=0", busy4); end
        rst = 1'b0;
        step();
        $display("reset done");
    endtask

    task automatic test_single_op();
        req_a[31:0] = 32'hBE99999A;
        req_b[31:0] = 32'h43FA2000;
        req_valid   = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_req_ready got=%b exp=01", req_ready); end
        step();
        req_valid = 2'b00;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_early_rsp got=%b exp=00", rsp_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
        step();
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid); end
        checks++; if (rsp_product !== 32'hC3161334) begin errors++; $display("FAIL single_product got=%h exp=c3161334", rsp_product); end
        $display("op id=%0d product=%h", grant_id, rsp_product);
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", busy); end
    endtask

    task automatic test_simultaneous();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_a     = {32'h3F800000, 32'h40000000};
        req_b     = {32'h40490FDB, 32'h40400000};
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL simul_first_ready got=%b exp=01", req_ready); end
        step();
        req_valid = 2'b10;
        step();
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL simul_rsp0 got=%b exp=01", rsp_valid); end
        checks++; if (rsp_product !== 32'h40C00000) begin errors++; $display("FAIL simul_prod0 got=%h exp=40c00000", rsp_product); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL simul_grant0 got=%b exp=0", grant_id); end
        $display("op id=%0d product=%h", grant_id, rsp_product);
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL simul_second_ready got=%b exp=10", req_ready); end
        step();
        req_valid = 2'b00;
        step();
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL simul_rsp1 got=%b exp=10", rsp_valid); end
        checks++; if (rsp_product !== 32'h40490FDB) begin errors++; $display("FAIL simul_prod1 got=%h exp=40490fdb", rsp_product); end
        checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL simul_grant1 got=%b exp=1", grant_id); end
        $display("op id=%0d product=%h", grant_id, rsp_product);
        rsp_ready = 2'b10;
        step();
        rsp_ready = 2'b00;
    endtask

    task automatic test_alternation();
        logic [31:0] a0 [3];
        logic [31:0] a1 [3];
        logic [31:0] p0 [3];
        logic [31:0] p1 [3];
        logic [1:0]  exp_ready;
        logic [31:0] exp_prod;
        int n0, n1, id;
        a0 = '{32'h3F800000, 32'h40000000, 32'h40400000};
        p0 = '{32'h40000000, 32'h40800000, 32'h40C00000};
        a1 = '{32'h40800000, 32'h40A00000, 32'h3F000000};
        p1 = '{32'hC0800000, 32'hC0A00000, 32'hBF000000};
        n0 = 0;
        n1 = 0;
        req_b     = {32'hBF800000, 32'h40000000};
        req_a     = {a1[0], a0[0]};
        req_valid = 2'b11;
        for (int op = 0; op < 6; op++) begin
            id        = op % 2;
            exp_ready = (id == 0) ? 2'b01 : 2'b10;
            #1;
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL alt_ready op=%0d got=%b exp=%b", op, req_ready, exp_ready); end
            step();
            if (id == 0) begin
                n0++;
                if (n0 < 3) req_a[31:0] = a0[n0]; else req_valid[0] = 1'b0;
                exp_prod = p0[n0-1];
            end else begin
                n1++;
                if (n1 < 3) req_a[63:32] = a1[n1]; else req_valid[1] = 1'b0;
                exp_prod = p1[n1-1];
            end
            step();
            checks++; if (rsp_valid !== exp_ready) begin errors++; $display("FAIL alt_rsp_valid op=%0d got=%b exp=%b", op, rsp_valid, exp_ready); end
            checks++; if (rsp_product !== exp_prod) begin errors++; $display("FAIL alt_product op=%0d got=%h exp=%h", op, rsp_product, exp_prod); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL alt_ready_in_resp op=%0d got=%b exp=00", op, req_ready); end
            $display("op id=%0d product=%h", grant_id, rsp_product);
            rsp_ready = exp_ready;
            step();
            rsp_ready = 2'b00;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_special();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] vp [3];
        va = '{32'h7F800000, 32'h00800000, 32'h7F000000};
        vb = '{32'h00000000, 32'h3F000000, 32'h40000000};
        vp = '{32'h7FC00000, 32'h00400000, 32'h7F800000};
        for (int i = 0; i < 3; i++) begin
            req_a[63:32] = va[i];
            req_b[63:32] = vb[i];
            req_valid    = 2'b10;
            step();
            req_valid = 2'b00;
            step();
            checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL special_valid i=%0d got=%b exp=10", i, rsp_valid); end
            checks++; if (rsp_product !== vp[i]) begin errors++; $display("FAIL special_product i=%0d got=%h exp=%h", i, rsp_product, vp[i]); end
            $display("op id=%0d product=%h", grant_id, rsp_product);
            rsp_ready = 2'b10;
            step();
            rsp_ready = 2'b00;
        end
    endtask

    task automatic test_backpressure();
        req_a[63:32] = 32'h40000000;
        req_b[63:32] = 32'hC0000000;
        req_valid    = 2'b10;
        step();
        req_valid = 2'b01;
        step();
        rsp_ready = 2'b01;
        for (int c = 0; c < 5; c++) begin
            checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL bp_valid c=%0d got=%b exp=10", c, rsp_valid); end
            checks++; if (rsp_product !== 32'hC0800000) begin errors++; $display("FAIL bp_product c=%0d got=%h exp=c0800000", c, rsp_product); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy c=%0d got=%b exp=1", c, busy); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_req_ready c=%0d got=%b exp=00", c, req_ready); end
            step();
        end
        $display("op id=%0d product=%h", grant_id, rsp_product);
        rsp_ready = 2'b10;
        step();
        rsp_ready = 2'b00;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL bp_release got=%b exp=00", rsp_valid); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_next_ready got=%b exp=01", req_ready); end
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_multicycle();
        req_a4[31:0] = 32'h40400000;
        req_b4[31:0] = 32'h40A00000;
        req_valid4   = 2'b01;
        #1;
        checks++; if (req_ready4 !== 2'b01) begin errors++; $display("FAIL mc_ready got=%b exp=01", req_ready4); end
        step();
        req_valid4   = 2'b00;
        req_a4[31:0] = 32'hFFFFFFFF;
        req_b4[31:0] = 32'h12345678;
        checks++; if (rsp_valid4 !== 2'b00) begin errors++; $display("FAIL mc_early edge=0 got=%b exp=00", rsp_valid4); end
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (rsp_valid4 !== 2'b00) begin errors++; $display("FAIL mc_early edge=%0d got=%b exp=00", k, rsp_valid4); end
            checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL mc_busy edge=%0d got=%b exp=1", k, busy4); end
        end
        step();
        checks++; if (rsp_valid4 !== 2'b01) begin errors++; $display("FAIL mc_valid got=%b exp=01", rsp_valid4); end
        checks++; if (rsp_product4 !== 32'h41700000) begin errors++; $display("FAIL mc_product got=%h exp=41700000", rsp_product4); end
        $display("op4 id=%0d product=%h", grant_id4, rsp_product4);
        rsp_ready4 = 2'b01;
        step();
        rsp_ready4 = 2'b00;
    endtask

    task automatic test_reset_mid_op();
        req_a4[63:32] = 32'h40000000;
        req_b4[63:32] = 32'h40000000;
        req_valid4    = 2'b10;
        step();
        req_valid4 = 2'b00;
        step();
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got=%b exp=1", busy4); end
        rst = 1'b1;
        #2;
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy4); end
        checks++; if (rsp_product4 !== 32'h0) begin errors++; $display("FAIL rmid_product got=%h exp=00000000", rsp_product4); end
        checks++; if (grant_id4 !== 1'b0) begin errors++; $display("FAIL rmid_grant got=%b exp=0", grant_id4); end
        checks++; if (rsp_valid4 !== 2'b00) begin errors++; $display("FAIL rmid_valid got=%b exp=00", rsp_valid4); end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++; if (rsp_valid4 !== 2'b00) begin errors++; $display("FAIL rmid_ghost c=%0d got=%b exp=00", c, rsp_valid4); end
        end
        req_valid4 = 2'b11;
        #1;
        checks++; if (req_ready4 !== 2'b01) begin errors++; $display("FAIL rmid_next_grant got=%b exp=01", req_ready4); end
        req_valid4 = 2'b00;
        $display("reset mid-op done");
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 2'b00;
        rsp_ready  = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_valid4 = 2'b00;
        rsp_ready4 = 2'b00;
        req_a4     = '0;
        req_b4     = '0;
        test_reset();
        test_single_op();
        test_simultaneous();
        test_alternation();
        test_special();
        test_backpressure();
        test_multicycle();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
